// File: rtl/serial_frame_receiver_pkg.sv
// Shared constants and types for the serial frame receive path.
// Frame on the wire, MSB first: {SYNCWORD, PAD (zeros), DATA}.
package serial_frame_receiver_pkg;

  localparam int                   SYNC_BITS  = 8;
  localparam logic [SYNC_BITS-1:0] SYNCWORD   = 8'hA5;
  localparam int                   PAD_BITS   = 8;
  localparam int                   DATA_BITS  = 208;
  localparam int                   FRAME_BITS = SYNC_BITS + PAD_BITS + DATA_BITS;

  typedef enum logic [1:0] {RX_HUNT, RX_PAD, RX_DATA} rx_state_t;

endpackage

// File: rtl/serial_frame_receiver_if.sv
// Control, serial line and payload-side signals of one receive lane.
// slave: the receiver; master: whoever drives the line and consumes payloads.
interface serial_frame_receiver_if #(
  parameter int DATA_BITS = serial_frame_receiver_pkg::DATA_BITS
);
  import serial_frame_receiver_pkg::*;

  logic                 game_active;
  logic                 serial_in;
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 frame_err;
  logic                 busy;

  modport slave (
    input  game_active, serial_in,
    output data_out, data_valid, frame_err, busy
  );

  modport master (
    output game_active, serial_in,
    input  data_out, data_valid, frame_err, busy
  );

endinterface

// File: rtl/serial_frame_receiver_bit_synchronizer.sv
// Two-flop synchronizer for one asynchronous bit; synchronous active-high
// reset clears both stages.
module bit_synchronizer (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  import serial_frame_receiver_pkg::*;

  logic meta;

  // Two back-to-back flops give the first stage a cycle to settle.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/serial_frame_receiver.sv
// Receive end of one serial data line: synchronizes serial_in, hunts for the
// sync word, skips the pad, deserializes the payload and pulses data_valid.
// Optional pad checking is enabled by defining RX_PAD_CHECK_EN; without it
// pad bits are ignored and frame_err stays 0.
module serial_frame_receiver #(
  parameter int                   SYNC_BITS = serial_frame_receiver_pkg::SYNC_BITS,
  parameter logic [SYNC_BITS-1:0] SYNCWORD  = serial_frame_receiver_pkg::SYNCWORD,
  parameter int                   PAD_BITS  = serial_frame_receiver_pkg::PAD_BITS,
  parameter int                   DATA_BITS = serial_frame_receiver_pkg::DATA_BITS
) (
  input  logic                   clk,
  input  logic                   rst,
  serial_frame_receiver_if.slave bus
);
  import serial_frame_receiver_pkg::*;

  // Counter covers both the pad and data phases.
  localparam int CNT_RANGE = (DATA_BITS > PAD_BITS) ? DATA_BITS : PAD_BITS;
  localparam int CW        = $clog2(CNT_RANGE);
  localparam logic [CW-1:0] PAD_LAST  = CW'(PAD_BITS - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);

  logic rx_bit;

  bit_synchronizer u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.serial_in),
    .q   (rx_bit)
  );

  // The sync and payload shifters keep only the bits that survive the next
  // shift; the incoming rx_bit completes the word combinationally, so the
  // oldest bit of each full-width register would never be read.
  rx_state_t              state_q, state_d;
  logic [SYNC_BITS-2:0]   sync_q,  sync_d;
  logic [CW-1:0]          cnt_q,   cnt_d;
  logic [DATA_BITS-2:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   dout_q,  dout_d;
  logic                   dv_q,    dv_d;
  logic [SYNC_BITS-1:0]   sync_word;
  logic [DATA_BITS-1:0]   data_word;
`ifdef RX_PAD_CHECK_EN
  logic                   pad_bad_q, pad_bad_d;
  logic                   fe_q,      fe_d;
`endif

  assign sync_word = {sync_q, rx_bit};
  assign data_word = {shift_q, rx_bit};

  // Next-state, counters, shifters and output pulses.
  always_comb begin
    state_d = state_q;
    sync_d  = sync_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    dout_d  = dout_q;
    dv_d    = 1'b0;
`ifdef RX_PAD_CHECK_EN
    pad_bad_d = pad_bad_q;
    fe_d      = 1'b0;
`endif
    unique case (state_q)
      RX_HUNT: begin
        sync_d = sync_word[SYNC_BITS-2:0];
`ifdef RX_PAD_CHECK_EN
        pad_bad_d = 1'b0;
`endif
        if (sync_word == SYNCWORD) begin
          // Clear so the next hunt needs a complete fresh sync word.
          state_d = RX_PAD;
          sync_d  = '0;
          cnt_d   = '0;
        end
      end
      RX_PAD: begin
        cnt_d = cnt_q + 1'b1;
`ifdef RX_PAD_CHECK_EN
        pad_bad_d = pad_bad_q | rx_bit;
`endif
        if (cnt_q == PAD_LAST) begin
          cnt_d = '0;
`ifdef RX_PAD_CHECK_EN
          if (pad_bad_q | rx_bit) begin
            state_d   = RX_HUNT;
            fe_d      = 1'b1;
            pad_bad_d = 1'b0;
          end else begin
            state_d = RX_DATA;
          end
`else
          state_d = RX_DATA;
`endif
        end
      end
      RX_DATA: begin
        shift_d = data_word[DATA_BITS-2:0];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == DATA_LAST) begin
          state_d = RX_HUNT;
          cnt_d   = '0;
          dout_d  = data_word;
          dv_d    = 1'b1;
        end
      end
      default: begin
        state_d = RX_HUNT;
        sync_d  = '0;
        cnt_d   = '0;
      end
    endcase
    // Leaving the game aborts everything, including a frame completing now.
    if (!bus.game_active) begin
      state_d = RX_HUNT;
      sync_d  = '0;
      cnt_d   = '0;
      dout_d  = dout_q;
      dv_d    = 1'b0;
`ifdef RX_PAD_CHECK_EN
      pad_bad_d = 1'b0;
      fe_d      = 1'b0;
`endif
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RX_HUNT;
      sync_q  <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
`ifdef RX_PAD_CHECK_EN
      pad_bad_q <= 1'b0;
      fe_q      <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
`ifdef RX_PAD_CHECK_EN
      pad_bad_q <= pad_bad_d;
      fe_q      <= fe_d;
`endif
    end
  end

  assign bus.data_out   = dout_q;
  assign bus.data_valid = dv_q;
  assign bus.busy       = (state_q != RX_HUNT);
`ifdef RX_PAD_CHECK_EN
  assign bus.frame_err  = fe_q;
`else
  assign bus.frame_err  = 1'b0;
`endif

endmodule
